sd_mount_ctrl: RTL

// - Parametrised successor to the single-slot virtual-SD select / reset-on-mount / SD-activity logic in the emu top.
// - Routes the core's SPI SD bus to the physical card or to one of NCH virtual image slots (sd_card instances).
// - Generates a timed cold-reset request on every mount event.
// - Defers slot switches until no SPI transaction is in flight.
// - Provides per-path activity flags for LED_USER / LED_DISK.

---
 rtl/sd_mount_pkg.sv | 60 ++++++
 rtl/sd_mount_ctrl_act.sv | 31 +++
 rtl/sd_mount_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sd_mount_pkg.sv
// Shared types and target-selection rules for the SD mount controller.
// Latency: combinational helpers only.
// Backpressure: none; pure functions and type definitions.
package sd_mount_pkg;

   typedef enum logic [1:0] {IDLE, PEND, HOLD} state_t;

   // Upper bound on slot count; the selection function works on this width.
   localparam int MAX_CH = 8;

   typedef struct packed {
      logic       virt;
      logic [3:0] idx;
   } target_t;

   // Width of the routed slot index for a given slot count.
   function automatic int sel_w(input int nch);
      return $clog2(nch) + 1;
   endfunction

   // New routing target after a set of simultaneous mount strobes.
   // A non-empty image always wins, lowest slot first. Removing the image
   // that is currently routed (or about to be) falls back to the
   // highest-index slot still holding an image, else to the physical card.
   function automatic target_t pick_target(
      input logic [MAX_CH-1:0] strobe,
      input logic [MAX_CH-1:0] size_nz,
      input logic [MAX_CH-1:0] mounted_nx,
      input target_t           cur,
      input target_t           pend
   );
      target_t res;
      logic    won;
      logic    hit;
      res = pend;
      won = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < MAX_CH; i++) begin
         if (strobe[i] && size_nz[i] && !won) begin
            res.virt = 1'b1;
            res.idx  = 4'(i);
            won      = 1'b1;
         end
         if (strobe[i] && !size_nz[i] &&
             ((cur.virt && cur.idx == 4'(i)) || (pend.virt && pend.idx == 4'(i))))
            hit = 1'b1;
      end
      if (!won && hit) begin
         res = '0;
         for (int i = 0; i < MAX_CH; i++) begin
            if (mounted_nx[i]) begin
               res.virt = 1'b1;
               res.idx  = 4'(i);
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/sd_mount_ctrl_act.sv
// Activity hold timer for one SD path (drives an LED flag).
// Latency: act rises the cycle after a registered toggle, holds ACT_CYCLES cycles.
// Backpressure: none; free-running saturating counter.
// Ports: clk_sys, reset_n (async, active-low), toggle (bus edge seen), act (flag out).
module sd_act_timer #(
   parameter int ACT_CYCLES = 1_000_000
) (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic toggle,
   output logic act
);

   localparam int TW = $clog2(ACT_CYCLES + 1);
   localparam logic [TW-1:0] SAT = TW'(ACT_CYCLES);

   logic [TW-1:0] timer;

   // Reset to saturation so the LED starts dark.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         timer <= SAT;
      else if (toggle)
         timer <= '0;
      else if (timer != SAT)
         timer <= timer + TW'(1);
   end

   assign act = (timer < SAT);

endmodule

// File: rtl/sd_mount_ctrl.sv
// SPI SD router between the physical card and NCH virtual slots, with cold-reset on mount.
// Latency: target commits on the first idle-CS cycle after a strobe; reset_req holds RST_CYCLES after commit.
// Backpressure: slot switches wait while sd_cs_n is low; strobes during a pending switch retarget it.
// Ports: clk_sys/reset_n; img_mounted/img_size_nz strobes; core SPI (sd_cs_n, sd_sck, sd_mosi, core_miso);
//        physical card (phys_*); virtual slots (vsd_ss_n, vsd_miso); status (sel_virt, sel_idx, reset_req, act).
module sd_mount_ctrl
   import sd_mount_pkg::*;
#(
   parameter int NCH        = 2,
   parameter int RST_CYCLES = 10_000_000,
   parameter int ACT_CYCLES = 1_000_000
) (
   input  logic                   clk_sys,
   input  logic                   reset_n,
   input  logic [NCH-1:0]         img_mounted,
   input  logic [NCH-1:0]         img_size_nz,
   input  logic                   sd_cs_n,
   input  logic                   sd_sck,
   input  logic                   sd_mosi,
   output logic                   core_miso,
   input  logic                   phys_miso,
   output logic                   phys_cs_n,
   output logic                   phys_sck,
   output logic                   phys_mosi,
   input  logic [NCH-1:0]         vsd_miso,
   output logic [NCH-1:0]         vsd_ss_n,
   output logic                   sel_virt,
   output logic [sel_w(NCH)-1:0]  sel_idx,
   output logic                   reset_req,
   output logic [NCH:0]           act
);

   localparam int SEL_W = sel_w(NCH);
   localparam int CNT_W = $clog2(RST_CYCLES + 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RST_CYCLES - 1);

   state_t           state;
   target_t          tgt;       // latest requested target; equals committed one outside PEND
   target_t          cur;
   target_t          nxt_tgt;
   logic [NCH-1:0]   mounted;
   logic [NCH-1:0]   mounted_nx;
   logic [CNT_W-1:0] cnt;
   logic             any_strobe;

   assign any_strobe = |img_mounted;
   assign mounted_nx = (mounted & ~img_mounted) | (img_mounted & img_size_nz);
   assign cur        = {sel_virt, 4'(sel_idx)};
   assign nxt_tgt    = pick_target(MAX_CH'(img_mounted), MAX_CH'(img_size_nz),
                                   MAX_CH'(mounted_nx), cur, tgt);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         tgt       <= '0;
         mounted   <= '0;
         cnt       <= '0;
         sel_virt  <= 1'b0;
         sel_idx   <= '0;
         reset_req <= 1'b0;
      end else begin
         if (any_strobe)
            mounted <= mounted_nx;
         case (state)
            IDLE: begin
               if (any_strobe) begin
                  tgt       <= nxt_tgt;
                  state     <= PEND;
                  reset_req <= 1'b1;
               end
            end
            PEND: begin
               // Only switch the bus while no transaction is in flight.
               if (any_strobe) begin
                  tgt <= nxt_tgt;
               end else if (sd_cs_n) begin
                  sel_virt <= tgt.virt;
                  sel_idx  <= tgt.idx[SEL_W-1:0];
                  cnt      <= HOLD_LOAD;
                  state    <= HOLD;
               end
            end
            HOLD: begin
               if (any_strobe) begin
                  tgt   <= nxt_tgt;
                  state <= PEND;
               end else if (cnt == '0) begin
                  state     <= IDLE;
                  reset_req <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Bus routing from the committed selection.
   logic [NCH:0] routed;

   assign phys_cs_n = sd_cs_n | sel_virt;
   assign phys_sck  = sd_sck  & ~phys_cs_n;
   assign phys_mosi = sd_mosi & ~phys_cs_n;

   always_comb begin
      vsd_ss_n  = '1;
      routed    = '0;
      core_miso = phys_miso;
      routed[0] = ~sel_virt;
      for (int k = 0; k < NCH; k++) begin
         vsd_ss_n[k]   = sd_cs_n | ~(sel_virt & (sel_idx == SEL_W'(k)));
         routed[k + 1] = sel_virt & (sel_idx == SEL_W'(k));
         if (sel_virt && sel_idx == SEL_W'(k))
            core_miso = vsd_miso[k];
      end
   end

   // Activity: edge on MOSI or the path's own MISO while that path is routed.
   logic         mosi_q;
   logic [NCH:0] miso_q;
   logic [NCH:0] miso_all;
   logic [NCH:0] toggle;

   assign miso_all = {vsd_miso, phys_miso};
   assign toggle   = routed & ({(NCH + 1){sd_mosi ^ mosi_q}} | (miso_all ^ miso_q));

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         mosi_q <= 1'b0;
         miso_q <= '0;
      end else begin
         mosi_q <= sd_mosi;
         miso_q <= miso_all;
      end
   end

   for (genvar p = 0; p <= NCH; p++) begin : g_act
      sd_act_timer #(
         .ACT_CYCLES (ACT_CYCLES)
      ) u_timer (
         .clk_sys (clk_sys),
         .reset_n (reset_n),
         .toggle  (toggle[p]),
         .act     (act[p])
      );
   end

endmodule
